// File: rtl/spmv_write_issue_pkg.sv
// Shared types and constants for the SpMV AXI4 write issue unit.
// State encoding, BRESP codes and the post-AW cool-down length live here.
package spmv_write_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_AW = 2'd2,
        ST_WAIT_W  = 2'd3
    } wr_state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'd0;
    localparam logic [1:0] BRESP_EXOKAY = 2'd1;
    localparam logic [1:0] BRESP_SLVERR = 2'd2;
    localparam logic [1:0] BRESP_DECERR = 2'd3;

    localparam int unsigned COLD_CYCLES    = 3;
    localparam int unsigned COLD_W         = 2;
    localparam int unsigned OUT_W          = 2;
    localparam int unsigned TAG_FIFO_DEPTH = 4;
    localparam int unsigned ERR_CNT_W      = 16;

    // Any non-OKAY write response is treated as an error.
    function automatic logic bresp_is_err(input logic [1:0] resp);
        return (resp == BRESP_EXOKAY) || (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
    endfunction

endpackage

// File: rtl/spmv_write_issue_if.sv
// Request, AXI4 write channel and completion-FIFO signals of the write issue unit.
// master = the issue unit itself, slave = scheduler / interconnect / retire side.
interface spmv_write_issue_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 6
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_data;
    logic [DATA_W/8-1:0]   req_strb;
    logic [TAG_W-1:0]      req_tag;

    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [1:0]            m_axi_bresp;

    logic                  Write_BUSY;
    logic                  Write_IDLE;
    logic                  Fifo_Done_Read;
    logic [TAG_W+1:0]      Fifo_Done_data;
    logic                  Fifo_Done_empty;
    logic                  Fifo_Done_full;

    modport master (
        input  req_valid, req_addr, req_data, req_strb, req_tag,
        output req_ready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_awready, m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output Write_BUSY, Write_IDLE,
        input  Fifo_Done_Read,
        output Fifo_Done_data, Fifo_Done_empty, Fifo_Done_full
    );

    modport slave (
        output req_valid, req_addr, req_data, req_strb, req_tag,
        input  req_ready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_awready, m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  Write_BUSY, Write_IDLE,
        output Fifo_Done_Read,
        input  Fifo_Done_data, Fifo_Done_empty, Fifo_Done_full
    );
endinterface

// File: rtl/spmv_write_issue_fifo.sv
// Show-ahead synchronous FIFO used for the tag queue and the completion queue.
// Writes when full and reads when empty are ignored.
module spmv_write_issue_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      count;
    logic                  do_wr;
    logic                  do_rd;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= bump(wptr);
            if (do_rd) rptr <= bump(rptr);
            if (do_wr && !do_rd)      count <= count + CNT_W'(1);
            else if (!do_wr && do_rd) count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/spmv_write_issue.sv
// AXI4 single-beat write issue unit: accepts tagged requests, drives AW/W, matches B to tags.
// Optional SPMV_WR_ERR_CNT_EN adds a saturating error-response counter and sticky error flag.
module spmv_write_issue
    import spmv_write_issue_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned TAG_W              = 6,
    parameter int unsigned MAX_OUTSTANDING    = 2,
    parameter int unsigned DONE_DEPTH         = 8
) (
    input  logic                clk,
    input  logic                rstn,
    spmv_write_issue_if.master  bus
`ifdef SPMV_WR_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] wr_err_cnt,
    output logic                 wr_err_sticky
`endif
);
    localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;

    wr_state_t                     state;
    logic [OUT_W-1:0]              outstanding;
    logic [COLD_W-1:0]             cold;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]             wstrb_q;

    logic             req_ready_c;
    logic             accept;
    logic             aw_hs;
    logic             w_hs;
    logic             bready_c;
    logic             b_take;
    logic [TAG_W-1:0] tag_head;
    logic             tag_empty;
    logic             tag_full;
    logic             done_full;

    assign req_ready_c = (state == ST_IDLE) && (cold == '0) &&
                         (outstanding < OUT_W'(MAX_OUTSTANDING)) && !tag_full;
    assign accept      = bus.req_valid & req_ready_c;
    assign aw_hs       = awvalid_q & bus.m_axi_awready;
    assign w_hs        = wvalid_q & bus.m_axi_wready;
    assign bready_c    = ~done_full;
    // A B beat with nothing outstanding is handshaken but otherwise dropped.
    assign b_take      = bus.m_axi_bvalid & bready_c & (outstanding != '0) & ~tag_empty;

    assign bus.req_ready     = req_ready_c;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wlast   = 1'b1;
    assign bus.m_axi_bready  = bready_c;
    assign bus.Fifo_Done_full = done_full;
    assign bus.Write_BUSY = (outstanding == OUT_W'(MAX_OUTSTANDING)) || (cold != '0) ||
                            (state != ST_IDLE);
    assign bus.Write_IDLE = (outstanding == '0) && (cold == '0) && (state == ST_IDLE);

    // Issue FSM, outstanding counter and AW cool-down.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            outstanding <= '0;
            cold        <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            if (aw_hs)            cold <= COLD_W'(COLD_CYCLES);
            else if (cold != '0)  cold <= cold - COLD_W'(1);

            if (accept && !b_take)      outstanding <= outstanding + OUT_W'(1);
            else if (!accept && b_take) outstanding <= outstanding - OUT_W'(1);

            if (accept) begin
                awaddr_q <= bus.req_addr;
                wdata_q  <= bus.req_data;
                wstrb_q  <= bus.req_strb;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SEND;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (aw_hs && w_hs) begin
                        state     <= ST_IDLE;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                    end else if (aw_hs) begin
                        state     <= ST_WAIT_W;
                        awvalid_q <= 1'b0;
                    end else if (w_hs) begin
                        state     <= ST_WAIT_AW;
                        wvalid_q  <= 1'b0;
                    end
                end
                ST_WAIT_W: begin
                    if (w_hs) begin
                        state    <= ST_IDLE;
                        wvalid_q <= 1'b0;
                    end
                end
                ST_WAIT_AW: begin
                    if (aw_hs) begin
                        state     <= ST_IDLE;
                        awvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    spmv_write_issue_fifo #(
        .DATA_WIDTH (TAG_W),
        .DEPTH      (TAG_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (accept),
        .wr_data (bus.req_tag),
        .rd_en   (b_take),
        .rd_data (tag_head),
        .empty   (tag_empty),
        .full    (tag_full)
    );

    spmv_write_issue_fifo #(
        .DATA_WIDTH (2 + TAG_W),
        .DEPTH      (DONE_DEPTH)
    ) u_done_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (b_take),
        .wr_data ({bus.m_axi_bresp, tag_head}),
        .rd_en   (bus.Fifo_Done_Read),
        .rd_data (bus.Fifo_Done_data),
        .empty   (bus.Fifo_Done_empty),
        .full    (done_full)
    );

`ifdef SPMV_WR_ERR_CNT_EN
    // Error responses on tracked B beats; counter saturates, flag holds until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_err_cnt    <= '0;
            wr_err_sticky <= 1'b0;
        end else if (b_take && bresp_is_err(bus.m_axi_bresp)) begin
            if (wr_err_cnt != '1) wr_err_cnt <= wr_err_cnt + ERR_CNT_W'(1);
            wr_err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/spmv_write_issue.md
Name: spmv_write_issue

Overview:
- AXI4 write-side issue unit for the SpMV kernel; it is the writer counterpart of the read issue path.
- Accepts tagged single-beat write requests, drives AW and W, and tracks outstanding writes until their B responses.
- Queues completion records {bresp, tag} for the kernel's result/retire logic.
- Sits between the result-writeback scheduler and the kernel's AXI master port.

Parameters:
- C_M_AXI_DATA_WIDTH, 64, W data width in bits.
- C_M_AXI_ADDR_WIDTH, 64, AW address width.
- TAG_W, 6, request tag width; matches {ServeNum[2:0], Seq[2:0]}.
- MAX_OUTSTANDING, 2, maximum issued writes awaiting B; legal range 1..3.
- DONE_DEPTH, 8, completion FIFO depth.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- req_valid  in  1  write request valid
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_addr  in  C_M_AXI_ADDR_WIDTH  byte address
- req_data  in  C_M_AXI_DATA_WIDTH  write data
- req_strb  in  C_M_AXI_DATA_WIDTH/8  byte strobes
- req_tag  in  TAG_W  {ServeNum, Seq}
- m_axi_awvalid / m_axi_awready  out/in  1  AW handshake
- m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  registered address
- m_axi_wvalid / m_axi_wready  out/in  1  W handshake
- m_axi_wdata  out  C_M_AXI_DATA_WIDTH  registered data
- m_axi_wstrb  out  C_M_AXI_DATA_WIDTH/8  registered strobes
- m_axi_wlast  out  1  constant 1 (single beat)
- m_axi_bvalid / m_axi_bready  in/out  1  B handshake
- m_axi_bresp  in  2  write response
- Write_BUSY  out  1  outstanding==MAX_OUTSTANDING | cold!=0 | state!=IDLE
- Write_IDLE  out  1  outstanding==0 & cold==0 & state==IDLE
- Fifo_Done_Read  in  1  pop completion FIFO
- Fifo_Done_data  out  2+TAG_W  {bresp, tag}
- Fifo_Done_empty / Fifo_Done_full  out  1  completion FIFO flags

Behaviour:
- Reset: one clock domain; reset is synchronous, active-low (rstn sampled on posedge clk).
- Reset values: state=IDLE, awvalid=0, wvalid=0, outstanding=0, cold=0, both FIFOs empty, Write_IDLE=1, Write_BUSY=0.
- req_ready = state==IDLE & cold==0 & outstanding<MAX_OUTSTANDING & ~tag FIFO full (combinational).
- Accept: on req_valid & req_ready, register addr/data/strb, push req_tag to tag FIFO, outstanding+1, and assert awvalid and wvalid the next cycle.
- States:
  - IDLE -> SEND on accept.
  - SEND: both valids high.
    - Both handshakes in the same cycle -> IDLE.
    - AW only -> WAIT_W.
    - W only -> WAIT_AW.
  - WAIT_W: wvalid high; -> IDLE on W handshake.
  - WAIT_AW: awvalid high; -> IDLE on AW handshake.
- Valids never drop, and payload never changes, before the corresponding handshake.
- cold: loads 3 on AW handshake, otherwise decrements to 0 and saturates. This gives at least 3 idle cycles between AW issues.
- bready = ~Fifo_Done_full.
- On bvalid & bready: pop tag FIFO, push {bresp, popped tag} to the completion FIFO, outstanding-1.
- Accept and B handshake in the same cycle: outstanding unchanged.
- B with outstanding==0 is a protocol violation: ignored, no push, counter stays 0.
- B may arrive before W completes; its effect is still applied in that cycle.
- Completion FIFO full: bready=0 and B is held off; no data is lost.
- Pop of an empty completion FIFO: no effect.
- Latency: request accept -> awvalid/wvalid = 1 cycle; B handshake -> Fifo_Done_empty deasserts next cycle.
- Reset mid-transaction drops all in-flight state immediately; no B tracking survives reset.

Optional Feature:
- Macro: SPMV_WR_ERR_CNT_EN.
- Defined: adds output wr_err_cnt[15:0], a saturating count of B handshakes with bresp!=2'b00, reset to 0. Also adds output wr_err_sticky, set on the first error and cleared only by reset.
- Undefined: neither port exists, and bresp is only forwarded to the completion FIFO.

Decomposition:
- Shared package: write FSM state encoding (IDLE, SEND, WAIT_AW, WAIT_W), BRESP constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), COLD_CYCLES=3.
- No new sub-module. The existing Fifo is instanced twice:
  - tag FIFO: DATA_WIDTH=TAG_W;
  - completion FIFO: DATA_WIDTH=2+TAG_W, DEPTH=DONE_DEPTH.

Test Plan:
- Single write: addr=0x1000, data=0xDEADBEEF, tag=6'o25, awready=wready=1, bresp=0 one cycle after W -> AW/W asserted 1 cycle after accept; Fifo_Done_data={0, 6'o25}; Write_IDLE returns 1 after cold drains.
- Skewed handshakes: wready held low 4 cycles, awready=1 -> state SEND->WAIT_W; wdata stable for all 4 cycles; req_ready=0 until IDLE.
- Outstanding limit: B withheld, 3 requests offered -> 2 accepted; third waits with req_ready=0 and Write_BUSY=1 until the first B.
- Ordering/tags: tags 1,2 issued, bresp 0 then 2 -> completion FIFO outputs {0,1} then {2,2}; with SPMV_WR_ERR_CNT_EN, wr_err_cnt=1 and wr_err_sticky=1.
- Backpressure: completion FIFO filled to 8 without pops -> bready=0 and bvalid held; one pop -> bready=1 the next cycle and the held B is accepted.
- Reset during WAIT_AW with outstanding=1 -> next cycle awvalid=0, Write_IDLE=1, Fifo_Done_empty=1.
